// File: rtl/mem_stage_pkg.sv
// Shared pipeline records, memory-op encodings and FSM state type for the
// memory stage and its lane-alignment helper.
package riscv_structures;

  // Execute -> memory pipeline record
  typedef struct packed {
    logic        valid;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic        is_final;
    logic        instr_done;
  } ex_to_mem_s;

  // Memory -> write-back pipeline record
  typedef struct packed {
    logic [4:0]  rd;
    logic        reg_write;
    logic [31:0] data;
    logic        is_final;
    logic        instr_done;
  } mem_to_wb_s;

  // Load/store width encodings carried in funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Size field (funct3[1:0]) shared by loads and stores
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Purely combinational byte-lane logic: store enables/data plus the
// misalignment flag on the request side, and load extraction/extension on
// the response side. The two halves use independent offset/funct3 inputs
// because the response is formatted from the registered request.
module lsu_align
  import riscv_structures::*;
#(
  parameter int XLEN   = 32,
  parameter int NBYTES = 4
) (
  input  logic [1:0]        addr_offset,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   store_data,
  output logic [NBYTES-1:0] be,
  output logic [XLEN-1:0]   wdata,
  output logic              misalign,
  input  logic [1:0]        ld_offset,
  input  logic [2:0]        ld_funct3,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   load_data
);

  logic [XLEN-1:0] rdata_shifted;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  // Store lanes and alignment; unknown sizes behave as full-word accesses
  always_comb begin
    be       = '1;
    wdata    = store_data;
    misalign = 1'b0;
    case (funct3[1:0])
      SZ_BYTE: begin
        be    = NBYTES'(1) << addr_offset;
        wdata = {NBYTES{store_data[7:0]}};
      end
      SZ_HALF: begin
        be       = addr_offset[1] ? 4'b1100 : 4'b0011;
        wdata    = {(NBYTES/2){store_data[15:0]}};
        misalign = addr_offset[0];
      end
      default: begin
        be       = '1;
        misalign = |addr_offset;
      end
    endcase
  end

  // Load extraction: pick the addressed lane, then sign/zero extend
  always_comb begin
    rdata_shifted = rdata >> {ld_offset, 3'b000};
    ld_byte       = rdata_shifted[7:0];
    ld_half       = ld_offset[1] ? rdata[31:16] : rdata[15:0];
    case (ld_funct3)
      F3_LB:   load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_LH:   load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3_LBU:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
      F3_LHU:  load_data = {{(XLEN-16){1'b0}}, ld_half};
      F3_LW:   load_data = rdata;
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: passes ALU results through in one cycle, runs loads/stores
// over a req/ack data port (holding the request stable until acked) and
// stalls upstream while an access is outstanding.
module mem_stage
  import riscv_structures::*;
#(
  parameter int XLEN   = 32,
  parameter int NBYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  ex_to_mem_s        ex_to_mem,
  output logic              mem_ready,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [NBYTES-1:0] dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  output mem_to_wb_s        mem_to_wb,
  output logic              misalign_fault
);

  mem_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [NBYTES-1:0] be_q, be_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [1:0]        offset_q, offset_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [4:0]        rd_q, rd_d;
  logic              reg_write_q, reg_write_d;
  logic              is_final_q, is_final_d;
  logic              instr_done_q, instr_done_d;
  mem_to_wb_s        wb_q, wb_d;
  logic              fault_q, fault_d;

  logic              accept;
  logic              is_mem;
  logic [NBYTES-1:0] lane_be;
  logic [XLEN-1:0]   lane_wdata;
  logic              lane_misalign;
  logic [XLEN-1:0]   load_data;

  assign mem_ready = (state_q == ST_IDLE);
  assign accept    = ex_to_mem.valid && mem_ready;
  assign is_mem    = ex_to_mem.mem_read || ex_to_mem.mem_write;

  lsu_align #(
    .XLEN   (XLEN),
    .NBYTES (NBYTES)
  ) u_align (
    .addr_offset (ex_to_mem.alu_result[1:0]),
    .funct3      (ex_to_mem.funct3),
    .store_data  (ex_to_mem.store_data),
    .be          (lane_be),
    .wdata       (lane_wdata),
    .misalign    (lane_misalign),
    .ld_offset   (offset_q),
    .ld_funct3   (funct3_q),
    .rdata       (dmem_rdata),
    .load_data   (load_data)
  );

  // Next-state: accept/issue in IDLE, hold the request until ack in WAIT_ACK
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    offset_d     = offset_q;
    funct3_d     = funct3_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    is_final_d   = is_final_q;
    instr_done_d = instr_done_q;
    wb_d         = '0;
    fault_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            wb_d.rd         = ex_to_mem.rd;
            wb_d.reg_write  = ex_to_mem.reg_write;
            wb_d.data       = ex_to_mem.alu_result;
            wb_d.is_final   = ex_to_mem.is_final;
            wb_d.instr_done = ex_to_mem.instr_done;
          end else if (lane_misalign) begin
            // Retire the instruction without touching memory or the RF
            fault_d         = 1'b1;
            wb_d.rd         = ex_to_mem.rd;
            wb_d.is_final   = ex_to_mem.is_final;
            wb_d.instr_done = ex_to_mem.instr_done;
          end else begin
            state_d      = ST_WAIT_ACK;
            req_d        = 1'b1;
            // A op flagged both read and write is executed as a store
            we_d         = ex_to_mem.mem_write;
            addr_d       = {ex_to_mem.alu_result[XLEN-1:2], 2'b00};
            be_d         = lane_be;
            wdata_d      = lane_wdata;
            offset_d     = ex_to_mem.alu_result[1:0];
            funct3_d     = ex_to_mem.funct3;
            rd_d         = ex_to_mem.rd;
            reg_write_d  = ex_to_mem.reg_write && !ex_to_mem.mem_write;
            is_final_d   = ex_to_mem.is_final;
            instr_done_d = ex_to_mem.instr_done;
          end
        end
      end
      ST_WAIT_ACK: begin
        if (dmem_ack) begin
          state_d         = ST_IDLE;
          req_d           = 1'b0;
          wb_d.rd         = rd_q;
          wb_d.reg_write  = reg_write_q;
          wb_d.data       = we_q ? '0 : load_data;
          wb_d.is_final   = is_final_q;
          wb_d.instr_done = instr_done_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any outstanding request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      offset_q     <= '0;
      funct3_q     <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      is_final_q   <= 1'b0;
      instr_done_q <= 1'b0;
      wb_q         <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      offset_q     <= offset_d;
      funct3_q     <= funct3_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      is_final_q   <= is_final_d;
      instr_done_q <= instr_done_d;
      wb_q         <= wb_d;
      fault_q      <= fault_d;
    end
  end

  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_be        = be_q;
  assign dmem_wdata     = wdata_q;
  assign mem_to_wb      = wb_q;
  assign misalign_fault = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected write-back records are queued at
// accept time and popped when the stage retires them; a data-memory
// responder with programmable wait states checks every request cycle.
module tb_mem_stage;
  import riscv_structures::*;

  logic        clk = 1'b0;
  logic        rst;
  ex_to_mem_s  ex_to_mem;
  logic        mem_ready;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  mem_to_wb_s  mem_to_wb;
  logic        misalign_fault;

  mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .ex_to_mem      (ex_to_mem),
    .mem_ready      (mem_ready),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_be        (dmem_be),
    .dmem_wdata     (dmem_wdata),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata),
    .mem_to_wb      (mem_to_wb),
    .misalign_fault (misalign_fault)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard and event bookkeeping
  mem_to_wb_s sb_q[$];
  int wb_count = 0;
  int last_wb_cyc = 0;
  int fault_cnt = 0;
  int last_fault_cyc = 0;
  int req_cycles = 0;

  // Responder configuration / expected request fields
  int          ack_wait = 0;
  int          rsp_cnt = 0;
  logic [31:0] rsp_rdata = '0;
  logic        stray_ack = 1'b0;
  logic [31:0] exp_addr = '0;
  logic        exp_we = 1'b0;
  logic [3:0]  exp_be = '0;
  logic [31:0] exp_wdata = '0;

  // Write-back monitor: every retired record must match the queue head
  always @(negedge clk) begin
    if (!rst) begin
      if (misalign_fault) begin
        fault_cnt++;
        last_fault_cyc = cyc;
      end
      if (mem_to_wb.instr_done || mem_to_wb.reg_write) begin
        mem_to_wb_s exp_rec;
        wb_count++;
        last_wb_cyc = cyc;
        $display("[TB] wb cyc=%0d rd=%0d we=%0b data=0x%08h final=%0b done=%0b",
                 cyc, mem_to_wb.rd, mem_to_wb.reg_write, mem_to_wb.data,
                 mem_to_wb.is_final, mem_to_wb.instr_done);
        if (sb_q.size() == 0) begin
          check_eq("wb_unexpected", 64'(mem_to_wb), 64'(0));
        end else begin
          exp_rec = sb_q.pop_front();
          check_eq("wb_record", 64'(mem_to_wb), 64'(exp_rec));
        end
      end
    end
  end

  // Data-memory responder: acks after ack_wait extra request cycles
  always @(negedge clk) begin
    dmem_ack = 1'b0;
    if (rst) begin
      rsp_cnt = 0;
    end else if (stray_ack) begin
      dmem_ack = 1'b1;
    end else if (dmem_req) begin
      req_cycles++;
      check_eq("req_ready_low", 64'(mem_ready), 64'(0));
      check_eq("dmem_addr", 64'(dmem_addr), 64'(exp_addr));
      check_eq("dmem_we", 64'(dmem_we), 64'(exp_we));
      if (exp_we) begin
        check_eq("dmem_be", 64'(dmem_be), 64'(exp_be));
        check_eq("dmem_wdata", 64'(dmem_wdata), 64'(exp_wdata));
      end
      if (rsp_cnt >= ack_wait) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rsp_rdata;
        rsp_cnt    = 0;
      end else begin
        rsp_cnt++;
      end
    end
  end

  function automatic ex_to_mem_s mk_ex(input logic [31:0] alu, input logic [31:0] sd,
                                       input logic [4:0] rd, input logic rw,
                                       input logic mr, input logic mw,
                                       input logic [2:0] f3, input logic fin,
                                       input logic done);
    ex_to_mem_s e;
    e.valid      = 1'b1;
    e.alu_result = alu;
    e.store_data = sd;
    e.rd         = rd;
    e.reg_write  = rw;
    e.mem_read   = mr;
    e.mem_write  = mw;
    e.funct3     = f3;
    e.is_final   = fin;
    e.instr_done = done;
    return e;
  endfunction

  function automatic mem_to_wb_s mk_wb(input logic [4:0] rd, input logic rw,
                                       input logic [31:0] data, input logic fin,
                                       input logic done);
    mem_to_wb_s w;
    w.rd         = rd;
    w.reg_write  = rw;
    w.data       = data;
    w.is_final   = fin;
    w.instr_done = done;
    return w;
  endfunction

  // Present a record and hold it until the stage accepts it
  task automatic send(input ex_to_mem_s e, input bit push, input mem_to_wb_s exp_rec,
                      output int acc_cyc);
    int n = 0;
    @(negedge clk);
    ex_to_mem = e;
    while (!mem_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_eq("accept_timeout", 64'(mem_ready), 64'(1));
    acc_cyc = cyc;
    if (push) sb_q.push_back(exp_rec);
    @(posedge clk);
    #1 ex_to_mem.valid = 1'b0;
  endtask

  // Wait for all expected records, then confirm the output is a bubble
  task automatic drain(input string tag);
    int n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check_eq({tag, "_drain"}, 64'(sb_q.size()), 64'(0));
    @(negedge clk);
    check_eq({tag, "_bubble"}, 64'(mem_to_wb), 64'(0));
  endtask

  initial begin
    int acc, acc2, r0, f0, w0;
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int acc, acc2, r0, f0, w0;
    rst        = 1'b1;
    ex_to_mem  = '0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 64'(mem_ready), 64'(1));
    check_eq("rst_req", 64'(dmem_req), 64'(0));
    check_eq("rst_be", 64'(dmem_be), 64'(0));
    check_eq("rst_addr", 64'(dmem_addr), 64'(0));
    check_eq("rst_wb", 64'(mem_to_wb), 64'(0));
    check_eq("rst_fault", 64'(misalign_fault), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // ALU pass-through, latency 1, no memory traffic
    r0 = req_cycles;
    send(mk_ex(32'h1234_5678, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1), 1'b1,
         mk_wb(5'd5, 1'b1, 32'h1234_5678, 1'b0, 1'b1), acc);
    drain("alu");
    check_eq("alu_latency", 64'(last_wb_cyc - acc), 64'(1));
    check_eq("alu_no_req", 64'(req_cycles - r0), 64'(0));

    // LB with three wait states
    exp_addr = 32'h1000; exp_we = 1'b0; ack_wait = 3; rsp_rdata = 32'h80FF_0000;
    r0 = req_cycles;
    send(mk_ex(32'h1003, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, F3_LB, 1'b0, 1'b1), 1'b1,
         mk_wb(5'd7, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b1), acc);
    drain("lb");
    check_eq("lb_req_cycles", 64'(req_cycles - r0), 64'(4));
    check_eq("lb_latency", 64'(last_wb_cyc - acc), 64'(5));

    // SH to upper half, ack in the first request cycle
    exp_addr = 32'h2000; exp_we = 1'b1; exp_be = 4'b1100; exp_wdata = 32'hBEEF_BEEF;
    ack_wait = 0;
    r0 = req_cycles;
    send(mk_ex(32'h2002, 32'h0000_BEEF, 5'd3, 1'b1, 1'b0, 1'b1, 3'b001, 1'b1, 1'b1), 1'b1,
         mk_wb(5'd3, 1'b0, 32'h0, 1'b1, 1'b1), acc);
    drain("sh");
    check_eq("sh_req_cycles", 64'(req_cycles - r0), 64'(1));
    check_eq("sh_latency", 64'(last_wb_cyc - acc), 64'(2));

    // SB with read+write both set behaves as a store
    exp_addr = 32'h5000; exp_we = 1'b1; exp_be = 4'b0010; exp_wdata = 32'hA5A5_A5A5;
    ack_wait = 2;
    r0 = req_cycles;
    send(mk_ex(32'h5001, 32'h1234_56A5, 5'd4, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0, 1'b1), 1'b1,
         mk_wb(5'd4, 1'b0, 32'h0, 1'b0, 1'b1), acc);
    drain("sb");
    check_eq("sb_req_cycles", 64'(req_cycles - r0), 64'(3));
    check_eq("sb_latency", 64'(last_wb_cyc - acc), 64'(4));

    // Misaligned LW and LH: no request, single fault pulse with the write-back
    r0 = req_cycles; f0 = fault_cnt;
    send(mk_ex(32'h3001, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, F3_LW, 1'b0, 1'b1), 1'b1,
         mk_wb(5'd9, 1'b0, 32'h0, 1'b0, 1'b1), acc);
    drain("lw_mis");
    check_eq("lw_mis_latency", 64'(last_wb_cyc - acc), 64'(1));
    check_eq("lw_mis_no_req", 64'(req_cycles - r0), 64'(0));
    check_eq("lw_mis_pulses", 64'(fault_cnt - f0), 64'(1));
    check_eq("lw_mis_fault_cyc", 64'(last_fault_cyc), 64'(last_wb_cyc));
    f0 = fault_cnt;
    send(mk_ex(32'h3003, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, F3_LH, 1'b1, 1'b1), 1'b1,
         mk_wb(5'd10, 1'b0, 32'h0, 1'b1, 1'b1), acc);
    drain("lh_mis");
    check_eq("lh_mis_pulses", 64'(fault_cnt - f0), 64'(1));
    check_eq("lh_mis_no_req", 64'(req_cycles - r0), 64'(0));

    // Reset while waiting for ack; a late ack must not produce a write-back
    exp_addr = 32'h6000; exp_we = 1'b0; ack_wait = 1000;
    send(mk_ex(32'h6000, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, F3_LW, 1'b0, 1'b1), 1'b0,
         mk_wb(5'd0, 1'b0, 32'h0, 1'b0, 1'b0), acc);
    repeat (2) @(negedge clk);
    check_eq("rw_req_pending", 64'(dmem_req), 64'(1));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rw_req_cleared", 64'(dmem_req), 64'(0));
    check_eq("rw_ready", 64'(mem_ready), 64'(1));
    check_eq("rw_wb_bubble", 64'(mem_to_wb), 64'(0));
    w0 = wb_count;
    ack_wait = 0;
    @(posedge clk);
    #1 stray_ack = 1'b1;
    @(posedge clk);
    #1 stray_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rw_stray_ack_wb", 64'(wb_count - w0), 64'(0));
    check_eq("rw_stray_ack_req", 64'(dmem_req), 64'(0));
    check_eq("rw_stray_ack_ready", 64'(mem_ready), 64'(1));

    // LHU followed back-to-back by an ALU op held while the stage stalls
    exp_addr = 32'h4000; exp_we = 1'b0; ack_wait = 1; rsp_rdata = 32'h8001_0000;
    w0 = wb_count;
    send(mk_ex(32'h4002, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, F3_LHU, 1'b0, 1'b1), 1'b1,
         mk_wb(5'd11, 1'b1, 32'h0000_8001, 1'b0, 1'b1), acc);
    send(mk_ex(32'hCAFE_F00D, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1), 1'b1,
         mk_wb(5'd12, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b1), acc2);
    drain("b2b");
    check_eq("b2b_accept_after_ack", 64'(acc2 - acc), 64'(3));
    check_eq("b2b_alu_latency", 64'(last_wb_cyc - acc2), 64'(1));
    check_eq("b2b_wb_count", 64'(wb_count - w0), 64'(2));

    // Remaining load formats on lane 2
    exp_addr = 32'h7000; exp_we = 1'b0; ack_wait = 0; rsp_rdata = 32'h00F0_0000;
    send(mk_ex(32'h7002, 32'h0, 5'd13, 1'b1, 1'b1, 1'b0, F3_LBU, 1'b0, 1'b1), 1'b1,
         mk_wb(5'd13, 1'b1, 32'h0000_00F0, 1'b0, 1'b1), acc);
    drain("lbu");
    rsp_rdata = 32'h9ABC_0000;
    send(mk_ex(32'h7002, 32'h0, 5'd14, 1'b1, 1'b1, 1'b0, F3_LH, 1'b0, 1'b1), 1'b1,
         mk_wb(5'd14, 1'b1, 32'hFFFF_9ABC, 1'b0, 1'b1), acc);
    drain("lh");

    check_eq("sb_empty_at_end", 64'(sb_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
